ristretto_fetch_unit: RTL and testbench
=======================================

// Module: ristretto_fetch_unit
// PURPOSE
// - Producer end of the prefetch-buffer/fetch-unit interface: on request, fetches one 32-bit word from instruction memory.
// - Sits between the IF-stage prefetch buffer (consumer) and the imem port.
// - Memory handshake is request/grant, then response-valid.
// - Owns the sequential fetch PC; a jump or trap redirects it.
// - Responses still in flight when a redirect occurs are discarded.
// PARAMETERS
// - DataWidth   32            instruction/rdata width
// - AddrWidth   32            address/PC width
// - BootAddr    32'h0000_0080 PC loaded at reset (bits [1:0] must be 0)
// PORTS
// - clk_i             in   1          clock; all state updates on posedge
// - rstn_i            in   1          reset, asynchronous, active-low
// - fu_fetch_i        in   1          consumer requests one instruction (sampled only in IDLE)
// - fu_busy_o         out  1          transaction in progress (state != IDLE)
// - fu_new_instr_o    out  1          1-cycle pulse: fu_instr_o valid
// - fu_instr_o        out  DataWidth  fetched instruction, held until next delivery
// - fu_instr_err_o    out  1          bus error for delivered word, valid with fu_new_instr_o
// - fu_current_pc_o   out  AddrWidth  next fetch address (pc_q); equals delivered addr+4 during pulse
// - fu_redirect_i     in   1          control/trap hazard: discard and restart at fu_redirect_pc_i
// - fu_redirect_pc_i  in   AddrWidth  redirect target; bits [1:0] ignored (forced 0)
// - imem_req_o        out  1          memory request
// - imem_addr_o       out  AddrWidth  request address (= pc_q)
// - imem_gnt_i        in   1          request accepted this cycle
// - imem_rvalid_i     in   1          response valid
// - imem_rdata_i      in   DataWidth  response data
// - imem_err_i        in   1          response error, qualified by imem_rvalid_i
// BEHAVIOUR
// - Reset values: pc_q=BootAddr, state=IDLE.
//   Outputs at reset: fu_busy_o=0, fu_new_instr_o=0, fu_instr_o=0, fu_instr_err_o=0, imem_req_o=0.
// - FSM states: IDLE, REQ, WAIT, FLUSH. Redirect takes priority over every other transition in the same cycle.
// - IDLE:
//   - fu_redirect_i: pc_q<=target, stay IDLE.
//   - else fu_fetch_i: go to REQ.
// - REQ:
//   - imem_req_o=1 with imem_addr_o=pc_q, held stable until gnt.
//   - gnt & no redirect: go to WAIT.
//   - redirect & gnt same cycle: pc_q<=target, go to FLUSH.
//   - redirect without gnt: request withdrawn, pc_q<=target, go to IDLE.
// - WAIT:
//   - imem_req_o=0.
//   - rvalid & no redirect:
//     - register fu_instr_o<=rdata and fu_instr_err_o<=err;
//     - pulse fu_new_instr_o next cycle;
//     - pc_q<=pc_q+4;
//     - go to IDLE.
//   - redirect & rvalid same cycle: data dropped, no pulse, pc_q<=target, go to IDLE.
//   - redirect without rvalid: pc_q<=target, go to FLUSH.
// - FLUSH:
//   - imem_req_o=0; the one outstanding response is awaited and dropped, no pulse.
//   - rvalid: go to IDLE.
//   - further redirect: pc_q<=new target, stay FLUSH (rvalid same cycle -> IDLE).
// - Latency:
//   - fu_fetch_i sampled at cycle 0, req at cycle 1.
//   - gnt at 1 and rvalid at 2 gives fu_new_instr_o at cycle 3.
//   - Pulse is coincident with state=IDLE, so fu_busy_o=0 in the pulse cycle.
// - At most one outstanding transaction; fu_fetch_i in REQ/WAIT/FLUSH is ignored (no queuing).
// - rvalid in IDLE or REQ is a protocol violation: ignored, assertion fires.
// - fu_new_instr_o is never asserted on a response that belonged to a transaction issued before a redirect.
// - pc_q arithmetic is modulo 2^AddrWidth: 32'hFFFF_FFFC + 4 wraps to 0.
// - Async reset mid-transaction returns to IDLE immediately.
//   A later rvalid is the environment's responsibility and is dropped as a violation.
// TESTING
// - Reset, fetch_i=1 at cyc0, gnt at cyc1, rvalid at cyc2 with rdata=32'h0000_0013
//   -> addr=0x80 at cyc1; cyc3 new_instr=1, instr=0x13, current_pc=0x84, busy=0.
// - gnt withheld 3 cycles -> req/addr stable through all 3 cycles; single pulse after rvalid; no second request issued.
// - Redirect to 0x200 in WAIT, rvalid 2 cycles later with 0xDEAD
//   -> no pulse, state FLUSH then IDLE; next fetch addr=0x200.
// - Redirect 0x300 coincident with rvalid in WAIT -> no pulse, current_pc=0x300, busy=0 next cycle.
// - Back-to-back fetch_i held high with gnt/rvalid immediate
//   -> one delivery every 3 cycles, addrs 0x80,0x84,0x88; pc at 0xFFFF_FFFC wraps to 0.
// - rvalid with imem_err_i=1 -> pulse with fu_instr_err_o=1; async reset asserted in REQ -> req=0 and pc=0x80 without waiting for a clock edge.

Source files
------------

// File: rtl/ristretto_fetch_unit_if.sv
// Instruction-memory request/grant/response-valid bus between the fetch unit and imem.
// The master drives the request; the slave grants it and returns one response later.
interface ristretto_fetch_unit_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
);
  logic                 req;
  logic [AddrWidth-1:0] addr;
  logic                 gnt;
  logic                 rvalid;
  logic [DataWidth-1:0] rdata;
  logic                 err;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata,
    output err
  );
endinterface

// File: rtl/ristretto_fetch_unit.sv
// Single-outstanding instruction fetcher feeding the IF-stage prefetch buffer.
// Owns the sequential PC; redirects restart it and drop responses already in flight.
module ristretto_fetch_unit #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter logic [AddrWidth-1:0] BootAddr  = 32'h0000_0080
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 fu_fetch_i,
  output logic                 fu_busy_o,
  output logic                 fu_new_instr_o,
  output logic [DataWidth-1:0] fu_instr_o,
  output logic                 fu_instr_err_o,
  output logic [AddrWidth-1:0] fu_current_pc_o,
  input  logic                 fu_redirect_i,
  input  logic [AddrWidth-1:0] fu_redirect_pc_i,
  ristretto_fetch_unit_if.master imem
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StFlush
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   pc_q, pc_d;
  logic [DataWidth-1:0]   instr_q, instr_d;
  logic                   instr_err_q, instr_err_d;
  logic                   new_instr_q, new_instr_d;
  logic [AddrWidth-1:0]   redirect_target;

  assign redirect_target = {fu_redirect_pc_i[AddrWidth-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    instr_err_d = instr_err_q;
    new_instr_d = 1'b0;
    imem.req    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fu_redirect_i) begin
          pc_d = redirect_target;
        end else if (fu_fetch_i) begin
          state_d = StReq;
        end
      end
      StReq: begin
        imem.req = 1'b1;
        if (fu_redirect_i) begin
          pc_d = redirect_target;
          // A grant in the redirect cycle still owes us one response to drain.
          state_d = imem.gnt ? StFlush : StIdle;
        end else if (imem.gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (fu_redirect_i) begin
          pc_d    = redirect_target;
          state_d = imem.rvalid ? StIdle : StFlush;
        end else if (imem.rvalid) begin
          instr_d     = imem.rdata;
          instr_err_d = imem.err;
          new_instr_d = 1'b1;
          pc_d        = pc_q + AddrWidth'(4);
          state_d     = StIdle;
        end
      end
      StFlush: begin
        if (fu_redirect_i) begin
          pc_d = redirect_target;
        end
        if (imem.rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      pc_q        <= BootAddr;
      instr_q     <= '0;
      instr_err_q <= 1'b0;
      new_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      instr_err_q <= instr_err_d;
      new_instr_q <= new_instr_d;
    end
  end

  assign imem.addr       = pc_q;
  assign fu_busy_o       = (state_q != StIdle);
  assign fu_new_instr_o  = new_instr_q;
  assign fu_instr_o      = instr_q;
  assign fu_instr_err_o  = instr_err_q;
  assign fu_current_pc_o = pc_q;

  // A response is only legal while one is owed to us.
  rvalid_only_when_owed: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    imem.rvalid |-> (state_q == StWait || state_q == StFlush)
  ) else $error("imem rvalid with no outstanding transaction");

endmodule

// File: tb/tb_ristretto_fetch_unit.sv
// Bench for ristretto_fetch_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model of the fetch unit held in the bench.
module tb_ristretto_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        busy, new_instr, instr_err;
  logic [31:0] instr, current_pc;

  ristretto_fetch_unit_if bus ();

  ristretto_fetch_unit dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .fu_fetch_i       (fetch),
    .fu_busy_o        (busy),
    .fu_new_instr_o   (new_instr),
    .fu_instr_o       (instr),
    .fu_instr_err_o   (instr_err),
    .fu_current_pc_o  (current_pc),
    .fu_redirect_i    (redirect),
    .fu_redirect_pc_i (redirect_pc),
    .imem             (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: a request waiting for grant, a granted response still owed,
  // and whether that owed response has been orphaned by a redirect.
  logic [31:0] m_pc;
  bit          m_pending, m_inflight, m_killed;
  bit          exp_pulse, exp_err;
  logic [31:0] exp_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h80;
    m_pending  = 0;
    m_inflight = 0;
    m_killed   = 0;
    exp_pulse  = 0;
    exp_err    = 0;
    exp_instr  = '0;
  endtask

  // One clock cycle: check current outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic f, input logic r, input logic [31:0] rpc, input logic g,
                      input logic v, input logic [31:0] d, input logic e);
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_pending || m_inflight));
    check("req", 32'(bus.req), 32'(m_pending));
    if (m_pending) check("addr", bus.addr, m_pc);
    check("current_pc", current_pc, m_pc);
    check("new_instr", 32'(new_instr), 32'(exp_pulse));
    check("instr", instr, exp_instr);
    if (exp_pulse) check("instr_err", 32'(instr_err), 32'(exp_err));

    fetch       = f;
    redirect    = r;
    redirect_pc = rpc;
    bus.gnt     = g;
    bus.rvalid  = v;
    bus.rdata   = d;
    bus.err     = e;

    exp_pulse = 0;
    if (r) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      if (m_pending) begin
        m_pending = 0;
        if (g) begin
          m_inflight = 1;
          m_killed   = 1;
        end
      end else if (m_inflight) begin
        if (v) m_inflight = 0;
        else   m_killed   = 1;
      end
    end else if (m_pending) begin
      if (g) begin
        m_pending  = 0;
        m_inflight = 1;
        m_killed   = 0;
      end
    end else if (m_inflight) begin
      if (v) begin
        m_inflight = 0;
        if (!m_killed) begin
          exp_pulse = 1;
          exp_instr = d;
          exp_err   = e;
          m_pc      = m_pc + 32'd4;
        end
      end
    end else if (f) begin
      m_pending = 1;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic f, r, g, v, e;
    logic [31:0] rpc, d;

    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.err    = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rstn = 1'b1;

    // Basic latency: fetch cyc0, gnt cyc1, rvalid cyc2, pulse cyc3.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("lat_req", 32'(bus.req), 32'd1);
    check("lat_addr", bus.addr, 32'h80);
    step(0, 0, 0, 0, 1, 32'h0000_0013, 0);
    idle_step();
    check("lat_pulse", 32'(new_instr), 32'd1);
    check("lat_instr", instr, 32'h13);
    check("lat_pc", current_pc, 32'h84);
    check("lat_busy", 32'(busy), 32'd0);

    // Grant withheld three cycles; no second request afterwards.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      check("stall_addr", bus.addr, 32'h84);
    end
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hCAFE_0001, 0);
    idle_step();
    check("stall_pulse", 32'(new_instr), 32'd1);
    idle_step();
    check("stall_no_req", 32'(bus.req), 32'd0);
    check("stall_single", 32'(new_instr), 32'd0);

    // Redirect in WAIT, late response dropped.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("flush_busy", 32'(busy), 32'd1);
    step(0, 0, 0, 0, 1, 32'hDEAD, 0);
    idle_step();
    check("flush_no_pulse", 32'(new_instr), 32'd0);
    check("flush_pc", current_pc, 32'h200);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("flush_next_addr", bus.addr, 32'h200);
    step(0, 0, 0, 0, 1, 32'h1111_2222, 0);

    // Redirect coincident with rvalid.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 32'h300, 0, 1, 32'h5555_AAAA, 0);
    idle_step();
    check("coinc_no_pulse", 32'(new_instr), 32'd0);
    check("coinc_pc", current_pc, 32'h300);
    check("coinc_busy", 32'(busy), 32'd0);

    // Back-to-back fetches from 0x80.
    step(0, 1, 32'h80, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      check("b2b_addr", bus.addr, 32'h80 + 32'(4 * k));
      step(1, 0, 0, 0, 1, 32'h100 + 32'(k), 0);
    end
    idle_step();
    check("b2b_last_pulse", 32'(new_instr), 32'd1);

    // PC wraps past the top of the address space; low redirect bits are ignored.
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("wrap_addr", bus.addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'h7777_0000, 0);
    idle_step();
    check("wrap_pc", current_pc, 32'h0);

    // Bus error propagates with the pulse.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 1);
    idle_step();
    check("err_flag", 32'(instr_err), 32'd1);

    // Asynchronous reset while requesting.
    step(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("rst_req_before", 32'(bus.req), 32'd1);
    fetch = 1'b0;
    rstn  = 1'b0;
    #1;
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_pc", current_pc, 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_instr", instr, 32'h0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic; responses only offered while the model owes one.
    for (int i = 0; i < 3000; i++) begin
      f   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      g   = ($urandom_range(0, 2) != 0);
      v   = m_inflight && ($urandom_range(0, 2) == 0);
      d   = $urandom;
      e   = ($urandom_range(0, 7) == 0);
      step(f, r, rpc, g, v, d, e);
    end
    idle_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
